grid_solve_ctrl: RTL



---
 rtl/grid_solve_ctrl_pkg.sv | 21 ++
 rtl/grid_solve_ctrl_if.sv | 29 ++
 rtl/grid_solve_ctrl_sat_counter.sv | 24 ++
 rtl/grid_solve_ctrl.sv | 109 ++++++++++
 4 files changed

// File: rtl/grid_solve_ctrl_pkg.sv
// Shared types for the grid run controller: state encoding, response status
// codes and the default counter width.
package grid_ctrl_pkg;

   localparam int CNT_W_DEFAULT = 32;

   typedef logic [2:0] state_t;
   localparam state_t ST_IDLE   = 3'd0;
   localparam state_t ST_CLEAR  = 3'd1;
   localparam state_t ST_START  = 3'd2;
   localparam state_t ST_RUN    = 3'd3;
   localparam state_t ST_REPORT = 3'd4;

   typedef enum logic [1:0] {
      RSP_SUCCESS    = 2'd0,
      RSP_NOSOLUTION = 2'd1,
      RSP_TIMEOUT    = 2'd2,
      RSP_ABORTED    = 2'd3
   } rsp_status_e;

endpackage

// File: rtl/grid_solve_ctrl_if.sv
// Host-side request/response bundle of the grid run controller.
interface grid_solve_ctrl_if #(
   parameter int CNT_W = 32
) ();

   // A request transfers on a cycle with req_valid & req_ready, a response on a
   // cycle with rsp_valid & rsp_ready; a raised valid and its payload stay put
   // until that transfer cycle.
   logic             req_valid;
   logic             req_ready;
   logic [CNT_W-1:0] timeout_limit;
   logic             abort;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [1:0]       rsp_status;
   logic [CNT_W-1:0] rsp_cycles;
   logic             busy;

   modport master (
      output req_valid, timeout_limit, abort, rsp_ready,
      input  req_ready, rsp_valid, rsp_status, rsp_cycles, busy
   );

   modport slave (
      input  req_valid, timeout_limit, abort, rsp_ready,
      output req_ready, rsp_valid, rsp_status, rsp_cycles, busy
   );

endinterface

// File: rtl/grid_solve_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; it holds at all-ones and never
// wraps.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] count,
   output logic         at_max
);

   assign at_max = &count;

   always_ff @(posedge clock) begin
      if (reset || clr) begin
         count <= '0;
      end else if (en && !at_max) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/grid_solve_ctrl.sv
// Run controller for the sudoku tile grid: clears the grid, pulses start, times
// the solve and reports how it ended.
module grid_solve_ctrl
   import grid_ctrl_pkg::*;
#(
   parameter int CNT_W        = CNT_W_DEFAULT,
   parameter int CLEAR_CYCLES = 2
) (
   input  logic              clock,
   input  logic              reset,
   grid_solve_ctrl_if.slave  host,
   output logic              grid_reset,
   output logic              grid_start,
   input  logic              grid_done_success,
   input  logic              grid_done_failure,
   output logic [2:0]        state_dbg
);

   state_t           state;
   logic [7:0]       clr_cnt;
   logic [CNT_W-1:0] limit_q;
   logic [CNT_W-1:0] rsp_cycles_q;
   rsp_status_e      rsp_status_q;

   logic [CNT_W-1:0] run_cnt;
   logic             run_at_max;
   logic [CNT_W-1:0] run_now;
   logic             timeout_hit;

   sat_counter #(.W(CNT_W)) u_run_cnt (
      .clock  (clock),
      .reset  (reset),
      .clr    (state == ST_START),
      .en     (state == ST_RUN),
      .count  (run_cnt),
      .at_max (run_at_max)
   );

   // run_cnt holds completed RUN cycles; run_now counts the current one too.
   assign run_now     = run_at_max ? run_cnt : run_cnt + 1'b1;
   assign timeout_hit = (limit_q != '0) && (run_now == limit_q);

   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= ST_IDLE;
         clr_cnt      <= '0;
         limit_q      <= '0;
         rsp_status_q <= RSP_SUCCESS;
         rsp_cycles_q <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (host.req_valid) begin
                  limit_q <= host.timeout_limit;
                  clr_cnt <= 8'(CLEAR_CYCLES);
                  state   <= ST_CLEAR;
               end
            end
            ST_CLEAR: begin
               clr_cnt <= clr_cnt - 1'b1;
               if (host.abort) begin
                  rsp_status_q <= RSP_ABORTED;
                  rsp_cycles_q <= '0;
                  state        <= ST_REPORT;
               end else if (clr_cnt == 8'd1) begin
                  state <= ST_START;
               end
            end
            ST_START: begin
               if (host.abort) begin
                  rsp_status_q <= RSP_ABORTED;
                  rsp_cycles_q <= '0;
                  state        <= ST_REPORT;
               end else begin
                  state <= ST_RUN;
               end
            end
            ST_RUN: begin
               // Grid outcome beats a simultaneous abort, abort beats timeout.
               if (grid_done_success || grid_done_failure || host.abort || timeout_hit) begin
                  rsp_cycles_q <= run_now;
                  state        <= ST_REPORT;
                  if (grid_done_success)      rsp_status_q <= RSP_SUCCESS;
                  else if (grid_done_failure) rsp_status_q <= RSP_NOSOLUTION;
                  else if (host.abort)        rsp_status_q <= RSP_ABORTED;
                  else                        rsp_status_q <= RSP_TIMEOUT;
               end
            end
            ST_REPORT: begin
               if (host.rsp_ready) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // The grid is held in reset by system reset as well as during CLEAR.
   assign grid_reset      = reset | (state == ST_CLEAR);
   assign grid_start      = (state == ST_START);
   assign host.req_ready  = (state == ST_IDLE);
   assign host.rsp_valid  = (state == ST_REPORT);
   assign host.busy       = (state != ST_IDLE);
   assign host.rsp_status = rsp_status_q;
   assign host.rsp_cycles = rsp_cycles_q;
   assign state_dbg       = state;

endmodule
